// File: rtl/si5338_cfg_seq.sv
// Si5338 register-programming sequencer feeding the basic_iic byte master (Start_Sig/Done_Sig).
// Define SEQ_ID_CHECK_EN to read and verify the device ID before the table is walked.
module si5338_cfg_seq #(
   parameter int         N_ENTRIES   = 64,
   parameter int         ROM_AW      = 6,
   parameter int         TIMEOUT_CYC = 100000,
   parameter logic [7:0] ID_ADDR     = 8'd2,
   parameter logic [7:0] ID_VALUE    = 8'd38
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [7:0]        id_value,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic [1:0]        iic_start,
   output logic [7:0]        iic_addr,
   output logic [7:0]        iic_wdata,
   input  logic [7:0]        iic_rdata,
   input  logic              iic_done,
   output logic              iic_rstn
);

   localparam logic [1:0]        START_WR    = 2'b01;
   localparam logic [1:0]        START_RD    = 2'b10;
   localparam logic [1:0]        ERR_TIMEOUT = 2'b01;
   localparam logic [1:0]        ERR_ID      = 2'b10;
   localparam logic [19:0]       TO_LAST     = 20'(TIMEOUT_CYC - 1);
   localparam logic [ROM_AW-1:0] LAST_IDX    = ROM_AW'(N_ENTRIES - 1);

   typedef enum logic [3:0] {
      IDLE, ID_RD, ID_CHK, FETCH, LATCH, RD, MERGE, WR, NEXT, FIN, RECOV, ERR
   } state_t;

`ifdef SEQ_ID_CHECK_EN
   localparam state_t FIRST_STATE = ID_RD;
`else
   localparam state_t FIRST_STATE = FETCH;
   logic [15:0] unusedIdParams_s;
   assign unusedIdParams_s = {ID_ADDR, ID_VALUE};
`endif

   function automatic logic [7:0] mergeByte(input logic [7:0] cur, input logic [7:0] val,
                                            input logic [7:0] msk);
      return (cur & ~msk) | (val & msk);
   endfunction

   state_t            state_r, nextState_s;
   logic              busy_r, busy_s, done_r, done_s, error_r, error_s;
   logic [1:0]        errCode_r, errCode_s;
   logic [7:0]        idValue_r, idValue_s;
   logic [ROM_AW-1:0] romAddr_r, romAddr_s;
   logic [1:0]        iicStart_r, iicStart_s;
   logic [7:0]        iicAddr_r, iicAddr_s, iicWdata_r, iicWdata_s;
   logic              iicRstn_r, iicRstn_s;
   logic [19:0]       toCnt_r, toCnt_s;
   logic              recovCnt_r, recovCnt_s;
   logic [7:0]        entData_r, entData_s, entMask_r, entMask_s, rdData_r, rdData_s;

   logic startOk_s, txnState_s, txnActive_s, txnDone_s, txnTimeout_s, lastEntry_s;

   // A transaction state spends one setup cycle with iic_start low before raising it.
   assign startOk_s    = start && ((state_r == IDLE) || (state_r == ERR));
   assign txnState_s   = (state_r == ID_RD) || (state_r == RD) || (state_r == WR);
   assign txnActive_s  = (iicStart_r != 2'b00);
   assign txnDone_s    = txnActive_s && iic_done;
   assign txnTimeout_s = txnActive_s && !iic_done && (toCnt_r == TO_LAST);
   assign lastEntry_s  = (romAddr_r == LAST_IDX);

   // State register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_r <= IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Next-state decode
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE, ERR: begin
            if (start) nextState_s = FIRST_STATE;
            else       nextState_s = state_r;
         end
`ifdef SEQ_ID_CHECK_EN
         ID_RD: begin
            if (txnTimeout_s)   nextState_s = RECOV;
            else if (txnDone_s) nextState_s = ID_CHK;
            else                nextState_s = ID_RD;
         end
         ID_CHK: begin
            if (idValue_r == ID_VALUE) nextState_s = FETCH;
            else                       nextState_s = ERR;
         end
`endif
         FETCH: nextState_s = LATCH;
         LATCH: begin
            if (rom_data[7:0] == 8'h00)      nextState_s = NEXT;
            else if (rom_data[7:0] == 8'hFF) nextState_s = WR;
            else                             nextState_s = RD;
         end
         RD: begin
            if (txnTimeout_s)   nextState_s = RECOV;
            else if (txnDone_s) nextState_s = MERGE;
            else                nextState_s = RD;
         end
         MERGE: nextState_s = WR;
         WR: begin
            if (txnTimeout_s)   nextState_s = RECOV;
            else if (txnDone_s) nextState_s = NEXT;
            else                nextState_s = WR;
         end
         NEXT: begin
            if (lastEntry_s) nextState_s = FIN;
            else             nextState_s = FETCH;
         end
         FIN: nextState_s = IDLE;
         RECOV: begin
            if (recovCnt_r) nextState_s = ERR;
            else            nextState_s = RECOV;
         end
         default: nextState_s = IDLE;
      endcase
   end

   // Output and datapath next values; every output is registered from these
   always_comb begin
      busy_s     = (nextState_s != IDLE) && (nextState_s != ERR) && (nextState_s != FIN);
      done_s     = (nextState_s == FIN);
      iicRstn_s  = (nextState_s != RECOV);
      recovCnt_s = (state_r == RECOV) ? ~recovCnt_r : 1'b0;
      error_s    = error_r;
      errCode_s  = errCode_r;
      romAddr_s  = romAddr_r;
      idValue_s  = idValue_r;
      iicStart_s = iicStart_r;
      iicAddr_s  = iicAddr_r;
      iicWdata_s = iicWdata_r;
      toCnt_s    = toCnt_r;
      entData_s  = entData_r;
      entMask_s  = entMask_r;
      rdData_s   = rdData_r;

      if (startOk_s) begin
         error_s   = 1'b0;
         errCode_s = 2'b00;
         romAddr_s = '0;
      end else if ((nextState_s == ERR) && (state_r != ERR)) begin
         error_s   = 1'b1;
         errCode_s = (state_r == RECOV) ? ERR_TIMEOUT : ERR_ID;
      end else if ((state_r == NEXT) && !lastEntry_s) begin
         romAddr_s = romAddr_r + ROM_AW'(1);
      end else begin
         romAddr_s = romAddr_r;
      end

      if (txnDone_s || txnTimeout_s) begin
         iicStart_s = 2'b00;
      end else if (txnState_s && !txnActive_s) begin
         iicStart_s = (state_r == WR) ? START_WR : START_RD;
      end else begin
         iicStart_s = iicStart_r;
      end

      if (txnState_s && !txnActive_s) toCnt_s = 20'd0;
      else if (txnActive_s)           toCnt_s = toCnt_r + 20'd1;
      else                            toCnt_s = toCnt_r;

      if (state_r == LATCH) begin
         iicAddr_s  = rom_data[23:16];
         iicWdata_s = rom_data[15:8];
         entData_s  = rom_data[15:8];
         entMask_s  = rom_data[7:0];
      end else if (state_r == MERGE) begin
         iicWdata_s = mergeByte(rdData_r, entData_r, entMask_r);
`ifdef SEQ_ID_CHECK_EN
      end else if (startOk_s) begin
         iicAddr_s = ID_ADDR;
`endif
      end else begin
         iicAddr_s = iicAddr_r;
      end

      if ((state_r == RD) && txnDone_s) rdData_s = iic_rdata;
      else                              rdData_s = rdData_r;

`ifdef SEQ_ID_CHECK_EN
      if ((state_r == ID_RD) && txnDone_s) idValue_s = iic_rdata;
      else                                 idValue_s = idValue_r;
`endif
   end

   // Output and datapath registers
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         errCode_r  <= 2'b00;
         idValue_r  <= 8'h00;
         romAddr_r  <= '0;
         iicStart_r <= 2'b00;
         iicAddr_r  <= 8'h00;
         iicWdata_r <= 8'h00;
         iicRstn_r  <= 1'b1;
         toCnt_r    <= 20'd0;
         recovCnt_r <= 1'b0;
         entData_r  <= 8'h00;
         entMask_r  <= 8'h00;
         rdData_r   <= 8'h00;
      end else begin
         busy_r     <= busy_s;
         done_r     <= done_s;
         error_r    <= error_s;
         errCode_r  <= errCode_s;
         idValue_r  <= idValue_s;
         romAddr_r  <= romAddr_s;
         iicStart_r <= iicStart_s;
         iicAddr_r  <= iicAddr_s;
         iicWdata_r <= iicWdata_s;
         iicRstn_r  <= iicRstn_s;
         toCnt_r    <= toCnt_s;
         recovCnt_r <= recovCnt_s;
         entData_r  <= entData_s;
         entMask_r  <= entMask_s;
         rdData_r   <= rdData_s;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign error     = error_r;
   assign err_code  = errCode_r;
   assign id_value  = idValue_r;
   assign rom_addr  = romAddr_r;
   assign iic_start = iicStart_r;
   assign iic_addr  = iicAddr_r;
   assign iic_wdata = iicWdata_r;
   assign iic_rstn  = iicRstn_r;

endmodule

// File: tb/tb_si5338_cfg_seq.sv
// Bench for si5338_cfg_seq: synchronous ROM model, byte-master model with a register file,
// and a transaction scoreboard (expected queue vs. observed queue).
module tb_si5338_cfg_seq;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] addr;
      logic [7:0] data;
      logic [5:0] idx;
   } txn_t;

`ifdef SEQ_ID_CHECK_EN
   localparam bit         ID_ON  = 1'b1;
   localparam logic [7:0] EXP_ID = 8'd38;
`else
   localparam bit         ID_ON  = 1'b0;
   localparam logic [7:0] EXP_ID = 8'd0;
`endif

   logic        CLK = 1'b0;
   logic        RSTn, start;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [7:0]  id_value;
   logic [5:0]  rom_addr;
   logic [23:0] rom_data = 24'h0;
   logic [1:0]  iic_start;
   logic [7:0]  iic_addr, iic_wdata, iic_rdata;
   logic        iic_done;
   logic        iic_rstn;

   int          errors = 0;
   int          checks = 0;
   txn_t        expQ[$];
   txn_t        obsQ[$];
   logic [7:0]  regs[256];
   logic [23:0] rom[64];
   bit          hang = 1'b0;
   int          stabViol = 0;
   int          gapViol = 0;
   int          wrStarts = 0;

   always #5 CLK = ~CLK;

   si5338_cfg_seq #(.N_ENTRIES(64), .ROM_AW(6), .TIMEOUT_CYC(50),
                    .ID_ADDR(8'd2), .ID_VALUE(8'd38)) dut (
      .CLK(CLK), .RSTn(RSTn), .start(start), .busy(busy), .done(done), .error(error),
      .err_code(err_code), .id_value(id_value), .rom_addr(rom_addr), .rom_data(rom_data),
      .iic_start(iic_start), .iic_addr(iic_addr), .iic_wdata(iic_wdata),
      .iic_rdata(iic_rdata), .iic_done(iic_done), .iic_rstn(iic_rstn)
   );

   always @(posedge CLK) rom_data <= rom[rom_addr];

   // Byte-master model: answers after 3 cycles with a one-cycle Done, checks handshake hygiene
   initial begin : master
      int         waitCnt;
      int         lowCnt;
      logic [1:0] prevStart;
      logic [7:0] prevAddr, prevWdata, hAddr, hWdata;
      iic_done = 1'b0; iic_rdata = 8'h00;
      waitCnt = 0; lowCnt = 99; prevStart = 2'b00;
      prevAddr = 8'h00; prevWdata = 8'h00; hAddr = 8'h00; hWdata = 8'h00;
      forever begin
         @(negedge CLK);
         if (!RSTn || !iic_rstn) begin
            iic_done = 1'b0; waitCnt = 0; lowCnt = 99; prevStart = 2'b00;
         end else begin
            if (iic_start != 2'b00) begin
               if (prevStart == 2'b00) begin
                  if (lowCnt < 2) gapViol++;
                  if (iic_addr !== prevAddr || (iic_start == 2'b01 && iic_wdata !== prevWdata))
                     stabViol++;
                  hAddr = iic_addr; hWdata = iic_wdata;
                  if (iic_start == 2'b01) wrStarts++;
               end else if (iic_addr !== hAddr || iic_wdata !== hWdata) begin
                  stabViol++;
               end
               lowCnt = 0;
            end else begin
               lowCnt++;
            end
            prevStart = iic_start; prevAddr = iic_addr; prevWdata = iic_wdata;
            if (iic_done) begin
               iic_done = 1'b0;
            end else if (iic_start != 2'b00 && !hang) begin
               if (waitCnt == 2) begin
                  waitCnt = 0;
                  if (iic_start == 2'b01) begin
                     regs[iic_addr] = iic_wdata;
                     obsQ.push_back({2'b01, iic_addr, iic_wdata, rom_addr});
                  end else begin
                     iic_rdata = regs[iic_addr];
                     obsQ.push_back({2'b10, iic_addr, regs[iic_addr], rom_addr});
                  end
                  iic_done = 1'b1;
               end else begin
                  waitCnt++;
               end
            end else begin
               waitCnt = 0;
            end
         end
      end
   end

   task automatic pulseStart();
      @(negedge CLK); start = 1'b1;
      @(negedge CLK); start = 1'b0;
   endtask

   task automatic pushExp(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d,
                          input logic [5:0] i);
      expQ.push_back({k, a, d, i});
   endtask

   // Waits for busy to drop (bounded) and counts done pulses, including a few cycles after
   task automatic runSeq(output int doneCnt, output bit timedOut, output bit busyAtDone);
      int n;
      doneCnt = 0; timedOut = 1'b1; busyAtDone = 1'b0; n = 0;
      while (n < 5000) begin
         @(negedge CLK); n++;
         if (done) begin doneCnt++; busyAtDone = busy; end
         if (!busy) begin timedOut = 1'b0; break; end
      end
      repeat (4) begin @(negedge CLK); if (done) doneCnt++; end
   endtask

   task automatic loadSmallTable();
      for (int i = 0; i < 64; i++) rom[i] = 24'h000000;
      rom[0] = 24'h10AAFF; rom[1] = 24'h115500; rom[2] = 24'h120FF0;
      regs[8'h02] = 8'd38; regs[8'h10] = 8'h00; regs[8'h11] = 8'h99; regs[8'h12] = 8'h3C;
      if (ID_ON) pushExp(2'b10, 8'h02, 8'd38, 6'd0);
      pushExp(2'b01, 8'h10, 8'hAA, 6'd0);
      pushExp(2'b10, 8'h12, 8'h3C, 6'd2);
      pushExp(2'b01, 8'h12, 8'h0C, 6'd2);
   endtask

   task automatic test_reset();
      RSTn = 1'b0; start = 1'b0;
      repeat (3) @(negedge CLK);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (error !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL rst_err: got %b/%b want 0/00", error, err_code); end
      checks++; if (id_value !== 8'h00 || rom_addr !== 6'd0) begin errors++; $display("FAIL rst_id_rom: got %h/%0d want 00/0", id_value, rom_addr); end
      checks++; if (iic_start !== 2'b00 || iic_addr !== 8'h00 || iic_wdata !== 8'h00) begin errors++; $display("FAIL rst_iic: got %b/%h/%h want 00/00/00", iic_start, iic_addr, iic_wdata); end
      checks++; if (iic_rstn !== 1'b1) begin errors++; $display("FAIL rst_iic_rstn: got %b want 1", iic_rstn); end
      @(negedge CLK); RSTn = 1'b1;
      repeat (3) @(negedge CLK);
      checks++; if (busy !== 1'b0 || iic_start !== 2'b00) begin errors++; $display("FAIL rst_idle: busy %b start %b want 0/00", busy, iic_start); end
   endtask

   task automatic test_table_basic();
      int dc; bit to, bd; txn_t e, o;
      expQ.delete(); obsQ.delete();
      loadSmallTable();
      pulseStart();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
      runSeq(dc, to, bd);
      checks++; if (to) begin errors++; $display("FAIL basic_timeout: busy still %b want 0", busy); end
      checks++; if (dc != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", dc); end
      checks++; if (bd !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", bd); end
      checks++; if (error !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL basic_err: got %b/%b want 0/00", error, err_code); end
      checks++; if (id_value !== EXP_ID) begin errors++; $display("FAIL basic_id_value: got %0d want %0d", id_value, EXP_ID); end
      checks++; if (regs[8'h12] !== 8'h0C || regs[8'h11] !== 8'h99) begin errors++; $display("FAIL basic_regs: got %h/%h want 0C/99", regs[8'h12], regs[8'h11]); end
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); checks++;
         if (obsQ.size() == 0) begin errors++; $display("FAIL basic_txn: got none want %h", e); end
         else begin o = obsQ.pop_front(); if (o !== e) begin errors++; $display("FAIL basic_txn: got %h want %h", o, e); end end
      end
      checks++; if (obsQ.size() != 0) begin errors++; $display("FAIL basic_extra_txn: got %0d extra want 0", obsQ.size()); end
   endtask

`ifdef SEQ_ID_CHECK_EN
   task automatic test_id_mismatch();
      int dc; bit to, bd; txn_t e, o;
      expQ.delete(); obsQ.delete();
      regs[8'h02] = 8'd37;
      pushExp(2'b10, 8'h02, 8'd37, 6'd0);
      pulseStart();
      runSeq(dc, to, bd);
      checks++; if (to || dc != 0) begin errors++; $display("FAIL idmis_end: timeout %b done %0d want 0/0", to, dc); end
      checks++; if (error !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL idmis_err: got %b/%b want 1/10", error, err_code); end
      checks++; if (id_value !== 8'd37) begin errors++; $display("FAIL idmis_id_value: got %0d want 37", id_value); end
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); checks++;
         if (obsQ.size() == 0) begin errors++; $display("FAIL idmis_txn: got none want %h", e); end
         else begin o = obsQ.pop_front(); if (o !== e) begin errors++; $display("FAIL idmis_txn: got %h want %h", o, e); end end
      end
      checks++; if (obsQ.size() != 0) begin errors++; $display("FAIL idmis_writes: got %0d extra want 0", obsQ.size()); end
      regs[8'h02] = 8'd38;
   endtask
`endif

   task automatic test_timeout();
      int n, m, k;
      expQ.delete(); obsQ.delete();
      hang = 1'b1;
      pulseStart();
      n = 0; m = 0; k = 0;
      while (iic_start == 2'b00 && k < 500) begin @(negedge CLK); k++; end
      while (iic_start != 2'b00 && n < 500) begin n++; @(negedge CLK); end
      checks++; if (n != 50) begin errors++; $display("FAIL to_start_cycles: got %0d want 50", n); end
      while (iic_rstn == 1'b0 && m < 50) begin m++; @(negedge CLK); end
      checks++; if (m != 2) begin errors++; $display("FAIL to_rstn_low: got %0d want 2", m); end
      checks++; if (error !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL to_err: got %b/%b want 1/01", error, err_code); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", busy); end
      checks++; if (obsQ.size() != 0) begin errors++; $display("FAIL to_txn: got %0d want 0", obsQ.size()); end
      hang = 1'b0;
   endtask

   task automatic test_restart_full();
      int dc; bit to, bd; txn_t e, o; logic [7:0] a, d;
      expQ.delete(); obsQ.delete();
      if (ID_ON) pushExp(2'b10, 8'h02, 8'd38, 6'd0);
      for (int i = 0; i < 64; i++) begin
         a = 8'h40 + 8'(i); d = 8'h01 + 8'(3 * i);
         rom[i] = {a, d, 8'hFF};
         pushExp(2'b01, a, d, 6'(i));
      end
      pulseStart();
      checks++; if (error !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL full_clear: got %b/%b want 0/00", error, err_code); end
      runSeq(dc, to, bd);
      checks++; if (to || dc != 1) begin errors++; $display("FAIL full_done: timeout %b done %0d want 0/1", to, dc); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL full_error: got %b want 0", error); end
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); checks++;
         if (obsQ.size() == 0) begin errors++; $display("FAIL full_txn: got none want %h", e); end
         else begin o = obsQ.pop_front(); if (o !== e) begin errors++; $display("FAIL full_txn: got %h want %h", o, e); end end
      end
      checks++; if (obsQ.size() != 0) begin errors++; $display("FAIL full_extra_txn: got %0d want 0", obsQ.size()); end
      checks++; if (stabViol != 0) begin errors++; $display("FAIL iic_hold: got %0d violations want 0", stabViol); end
      checks++; if (gapViol != 0) begin errors++; $display("FAIL iic_gap: got %0d violations want 0", gapViol); end
   endtask

   task automatic test_busy_start();
      int dc, k; bit to, bd; txn_t e, o;
      expQ.delete(); obsQ.delete();
      loadSmallTable();
      pulseStart();
      k = 0;
      while (obsQ.size() < 1 && k < 500) begin @(negedge CLK); k++; end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bs_busy: got %b want 1", busy); end
      pulseStart(); pulseStart();
      runSeq(dc, to, bd);
      checks++; if (to || dc != 1) begin errors++; $display("FAIL bs_done: timeout %b done %0d want 0/1", to, dc); end
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); checks++;
         if (obsQ.size() == 0) begin errors++; $display("FAIL bs_txn: got none want %h", e); end
         else begin o = obsQ.pop_front(); if (o !== e) begin errors++; $display("FAIL bs_txn: got %h want %h", o, e); end end
      end
      checks++; if (obsQ.size() != 0) begin errors++; $display("FAIL bs_second_seq: got %0d extra want 0", obsQ.size()); end
   endtask

   task automatic test_abort();
      int base, k; bit sawDone, sawBusy, sawStart; logic [37:0] v;
      for (int i = 0; i < 64; i++) rom[i] = {8'h40 + 8'(i), 8'h77, 8'hFF};
      base = wrStarts; k = 0;
      pulseStart();
      while (!(wrStarts == base + 3 && iic_start == 2'b01) && k < 2000) begin @(negedge CLK); k++; end
      checks++; if (k >= 2000) begin errors++; $display("FAIL abort_reach_wr3: got %0d writes want 3", wrStarts - base); end
      RSTn = 1'b0;
      #1;
      v = {busy, done, error, err_code, id_value, rom_addr, iic_start, iic_addr, iic_wdata, iic_rstn};
      checks++; if (v !== 38'd1) begin errors++; $display("FAIL abort_reset_vals: got %h want %h", v, 38'd1); end
      @(negedge CLK); RSTn = 1'b1;
      sawDone = 1'b0; sawBusy = 1'b0; sawStart = 1'b0;
      repeat (40) begin
         @(negedge CLK);
         if (done) sawDone = 1'b1;
         if (busy) sawBusy = 1'b1;
         if (iic_start != 2'b00) sawStart = 1'b1;
      end
      checks++; if (sawDone) begin errors++; $display("FAIL abort_no_done: got done pulse want none"); end
      checks++; if (sawBusy || sawStart) begin errors++; $display("FAIL abort_quiet: busy %b start %b want 0/0", sawBusy, sawStart); end
   endtask

   initial begin
      RSTn = 1'b0; start = 1'b0;
      for (int i = 0; i < 256; i++) regs[i] = 8'h00;
      for (int i = 0; i < 64; i++) rom[i] = 24'h000000;
      test_reset();
      test_table_basic();
`ifdef SEQ_ID_CHECK_EN
      test_id_mismatch();
`endif
      test_timeout();
      test_restart_full();
      test_busy_start();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
